// File: rtl/cmd_reg_target.sv
// cmd_reg_target: command consumer that decodes register write/read commands
// from the parser byte stream into a bank of 32-bit control registers and
// pushes read replies as bytes into the reply FIFO.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | wait for our mask bit, ack and capture the opcode
// ADDR   | ack and capture the register address byte
// DATA   | ack four little-endian data bytes; write lands on entry to COMMIT
// COMMIT | reg_wr strobe cycle, new register value already visible
// RDCAP  | latch the read word (0 for an out-of-range address)
// REPLY  | emit addr + 4 data bytes, stalling while reply_full is high
// DRAIN  | ack and discard trailing bytes until the mask bit drops
module cmd_reg_target #(
  parameter int MASK_BIT = 0,
  parameter int N_REGS   = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          cmd_mask,
  input  logic [7:0]          data,
  output logic [7:0]          data_ack,
  output logic [32*N_REGS-1:0] regs,
  output logic                reg_wr,
  output logic [ADDR_W-1:0]   reg_wr_addr,
  output logic [7:0]          reply_data,
  output logic                reply_wr,
  input  logic                reply_full,
  output logic [7:0]          err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_COMMIT, S_RDCAP, S_REPLY, S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic                gap_q, gap_d;
  logic                is_rd_q, is_rd_d;
  logic [7:0]          addr_q, addr_d;
  logic [23:0]         word_q, word_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [39:0]         reply_sh_q, reply_sh_d;
  logic [31:0]         regs_q [N_REGS];
  logic [31:0]         regs_d [N_REGS];
  logic                reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0]   reg_wr_addr_q, reg_wr_addr_d;
  logic [7:0]          err_q, err_d;

  logic                mask_hi;
  logic                ack_ok;
  logic                ack;
  logic                err_inc;
  logic                reply_go;
  logic                addr_ok;
  logic [ADDR_W-1:0]   addr_idx;
  logic [31:0]         word_full;
  logic [31:0]         rd_word;

  assign mask_hi   = cmd_mask[MASK_BIT];
  // a byte is only popped every other cycle so the parser can advance
  assign ack_ok    = mask_hi && !gap_q;
  assign addr_ok   = ({24'd0, addr_q} < 32'(N_REGS));
  assign addr_idx  = addr_q[ADDR_W-1:0];
  // bytes shift in from the top, so after d3 the word reads {d3,d2,d1,d0}
  assign word_full = {data, word_q};
  assign rd_word   = addr_ok ? regs_q[addr_idx] : 32'd0;

  // next-state, datapath and strobe decode
  always_comb begin
    state_d       = state_q;
    gap_d         = 1'b0;
    is_rd_d       = is_rd_q;
    addr_d        = addr_q;
    word_d        = word_q;
    cnt_d         = cnt_q;
    reply_sh_d    = reply_sh_q;
    regs_d        = regs_q;
    reg_wr_d      = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    ack           = 1'b0;
    err_inc       = 1'b0;
    reply_go      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ack_ok) begin
          ack = 1'b1;
          if (data == 8'h01 || data == 8'h02) begin
            is_rd_d = (data == 8'h02);
            state_d = S_ADDR;
          end else begin
            err_inc = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_ADDR: begin
        if (!mask_hi) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else if (ack_ok) begin
          ack     = 1'b1;
          addr_d  = data;
          cnt_d   = 3'd3;
          state_d = is_rd_q ? S_RDCAP : S_DATA;
        end
      end
      S_DATA: begin
        if (!mask_hi) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else if (ack_ok) begin
          ack    = 1'b1;
          word_d = word_full[31:8];
          if (cnt_q == 3'd0) begin
            // commit at this edge so the register and strobe appear together
            state_d = S_COMMIT;
            if (addr_ok) begin
              regs_d[addr_idx] = word_full;
              reg_wr_d         = 1'b1;
              reg_wr_addr_d    = addr_idx;
            end else begin
              err_inc = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_DRAIN;
      end
      S_RDCAP: begin
        reply_sh_d = {rd_word, addr_q};
        err_inc    = !addr_ok;
        cnt_d      = 3'd4;
        state_d    = S_REPLY;
      end
      S_REPLY: begin
        if (!reply_full) begin
          reply_go   = 1'b1;
          reply_sh_d = {8'd0, reply_sh_q[39:8]};
          if (cnt_q == 3'd0) state_d = S_DRAIN;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      S_DRAIN: begin
        if (ack_ok)        ack     = 1'b1;
        else if (!mask_hi) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    gap_d = ack;
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // output drive; strobes are forced low while reset is asserted
  always_comb begin
    data_ack           = 8'd0;
    data_ack[MASK_BIT] = ack && !reset;
    reply_wr           = reply_go && !reset;
    reply_data         = (state_q == S_REPLY && !reset) ? reply_sh_q[7:0] : 8'd0;
  end

  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign err_count   = err_q;

  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_flat
    assign regs[32*gi +: 32] = regs_q[gi];
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      gap_q         <= 1'b0;
      is_rd_q       <= 1'b0;
      addr_q        <= 8'd0;
      word_q        <= 24'd0;
      cnt_q         <= 3'd0;
      reply_sh_q    <= 40'd0;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= '0;
      err_q         <= 8'd0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= 32'd0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      is_rd_q       <= is_rd_d;
      addr_q        <= addr_d;
      word_q        <= word_d;
      cnt_q         <= cnt_d;
      reply_sh_q    <= reply_sh_d;
      reg_wr_q      <= reg_wr_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      err_q         <= err_d;
      regs_q        <= regs_d;
    end
  end

endmodule

// File: doc/cmd_reg_target.md
Name: cmd_reg_target

Overview:
- Command-consumer stage downstream of the command parser. Owns one bit of the parser's per-target `cmd_mask` and pops command bytes via its `data_ack` bit.
- Decodes register-write and register-read commands into a bank of 32-bit control registers. Counter and timer configuration in the timetag core is taken from this bank.
- Read replies are pushed as bytes into the upstream reply FIFO toward the FX2 interface.

Parameters:
- MASK_BIT, 0, index of the `cmd_mask`/`data_ack` bit owned by this target (0..7).
- N_REGS, 8, number of 32-bit registers (1..256).
- ADDR_W, 3, register index width (clog2 of N_REGS, min 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_mask  in  8  parser target select; bit MASK_BIT high means a command for us is in progress.
- data  in  8  current command byte from the parser; valid while the mask bit is high.
- data_ack  out  8  byte pop; only bit MASK_BIT is driven, all other bits are constant 0.
- regs  out  32*N_REGS  flattened register bank; register i is at bits [32i+31:32i].
- reg_wr  out  1  one-cycle strobe when a register is written.
- reg_wr_addr  out  ADDR_W  index of the register written; valid with `reg_wr`.
- reply_data  out  8  reply byte.
- reply_wr  out  1  reply FIFO write enable.
- reply_full  in  1  reply FIFO full.
- err_count  out  8  saturating count of malformed commands.

Behaviour:
- Reset (synchronous, active-high):
  - Every register is cleared to 0, as are `data_ack`, `reg_wr`, `reg_wr_addr`, `reply_wr`, `reply_data` and `err_count`.
  - The FSM returns to IDLE.
  - Reset mid-command abandons the command; no write occurs.
- Byte handshake:
  - The block samples `data` in the cycle it asserts `data_ack[MASK_BIT]`.
  - `data_ack` is then held low for exactly one cycle so the parser can present the next byte.
  - Maximum consumption rate is one byte per 2 cycles. `data_ack` is never asserted while the mask bit is low.
- Command format (bytes in order):
  - Write: `0x01`, addr, d0, d1, d2, d3. The value is little-endian, so d0 = bits [7:0].
  - Read: `0x02`, addr.
- FSM states:
  - IDLE: if the mask bit is high, ack and capture the opcode. Opcode `0x01` or `0x02` goes to ADDR; any other opcode goes to DRAIN and increments `err_count`.
  - ADDR: ack and capture addr. Write goes to DATA with byte index 0; read goes to RDCAP.
  - DATA: ack four bytes into a 32-bit shift/assembly register. After the fourth byte, go to COMMIT.
  - COMMIT (1 cycle):
    - If addr < N_REGS: `regs[addr]` is updated, and `reg_wr` = 1 with `reg_wr_addr` = addr in this same cycle.
    - Otherwise no update and `err_count` increments.
    - Then go to DRAIN.
  - RDCAP (1 cycle): latch the read word (0 if addr ≥ N_REGS, which also increments `err_count`). Go to REPLY.
  - REPLY: emit 5 bytes in order: addr, w[7:0], w[15:8], w[23:16], w[31:24].
    - One byte per cycle while `reply_full` = 0.
    - While `reply_full` = 1, `reply_wr` = 0 and `reply_data` holds.
    - After the 5th byte, go to DRAIN.
  - DRAIN: ack and discard bytes, at the normal rate, while the mask bit is high. Return to IDLE when the mask bit is low.
- Mask bit falls before a write's 6th byte is acked (short command): return to IDLE, no register update, `err_count` increments.
- Mask bit falls during RDCAP/REPLY: the reply still completes in full.
- Trailing bytes beyond the command format are silently discarded in DRAIN; this is not an error.
- `err_count` saturates at 255.
- `regs` outputs are registered; a new value is visible in the same cycle as `reg_wr`.
- Latency: `reg_wr` asserts 1 cycle after the ack of d3. The first `reply_wr` asserts 2 cycles after the ack of addr when `reply_full` = 0.

Test Plan:
1. Write then readback:
   - Mask bit 0 high, bytes `01 03 78 56 34 12`, then mask low. Expect `regs[3]` = `0x12345678` and one `reg_wr` pulse with addr 3. Exactly 6 acks, spaced ≥ 2 cycles apart.
   - Then read `02 03`. Expect reply bytes `03 78 56 34 12`.
2. Bad address and bad opcode:
   - Write with addr `0x09` (N_REGS = 8): no `reg_wr`, `err_count` = 1, bank unchanged.
   - Read addr `0x09`: reply `09 00 00 00 00`, `err_count` = 2.
   - Opcode `0x7F`: all bytes drained, `err_count` = 3.
3. Reply backpressure: read reg 3 with `reply_full` held high for 10 cycles from the first reply byte. Expect `reply_wr` low throughout that window, no bytes lost or duplicated, and order `03 78 56 34 12`.
4. Short and long commands:
   - Mask drops after `01 02 AA`: no write, `err_count` increments, FSM back in IDLE, and the next valid write succeeds.
   - Command `01 02 11 22 33 44 55 66`: `regs[2]` = `0x44332211`, 8 acks total, no error.
5. Mask isolation: MASK_BIT = 2, drive `cmd_mask` = `0x01` with bytes present. Expect `data_ack` = 0 and no activity. With `cmd_mask` = `0x04`, expect only `data_ack[2]` to toggle.
6. Reset mid-command: assert reset after the d1 ack. Expect all regs = 0, outputs at reset values, and IDLE on release. A fresh write then completes correctly.
